irq_timer_unit: RTL

- Memory-mapped interrupt source that drives the core's single `interrupt` input, directly upstream of the CSR interrupt logic.
- Contains a 64-bit machine timer (mtime/mtimecmp) with a prescaler, and edge-triggered external IRQ lines with pending/enable registers.
- Its register window sits on the load/store bus beside data memory (cs/wr/mask/addr/data_wr in, data_rd/valid out).

---
 rtl/irq_timer_unit.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/irq_timer_unit.sv
// irq_timer_unit: memory-mapped 64-bit machine timer (mtime/mtimecmp with a
// prescaler) plus edge-triggered external interrupt lines with pending and
// enable registers, merged into one registered interrupt request.
// Build macro IRQ_TIMER_EXT_SYNC_EN: when defined, every ext_irq line passes
// through a 2-flop synchronizer before edge detection; when undefined a single
// sampling flop is used (synchronous sources only).

module irq_timer_unit #(
  parameter int NUM_EXT = 4,
  parameter int PRESC_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cs,
  input  logic               wr,
  input  logic [3:0]         mask,
  input  logic [31:0]        addr,
  input  logic [31:0]        data_wr,
  output logic [31:0]        data_rd,
  output logic               valid,
  input  logic [NUM_EXT-1:0] ext_irq,
  output logic               interrupt
);

  localparam logic [2:0] OFF_MTIME_LO = 3'd0;
  localparam logic [2:0] OFF_MTIME_HI = 3'd1;
  localparam logic [2:0] OFF_CMP_LO   = 3'd2;
  localparam logic [2:0] OFF_CMP_HI   = 3'd3;
  localparam logic [2:0] OFF_CTRL     = 3'd4;
  localparam logic [2:0] OFF_PEND     = 3'd5;
  localparam logic [2:0] OFF_EN       = 3'd6;

  logic [63:0]        r_mtime;
  logic [63:0]        r_mtimecmp;
  logic               r_ten;
  logic               r_tie;
  logic [PRESC_W-1:0] r_presc;
  logic [PRESC_W-1:0] r_pcnt;
  logic [NUM_EXT-1:0] r_extPend;
  logic [NUM_EXT-1:0] r_extEn;
  logic [NUM_EXT-1:0] r_extSample;
  logic [NUM_EXT-1:0] r_extPrev;

  logic               w_wrEn;
  logic               w_rdEn;
  logic [7:0]         w_wrSel;
  logic [31:0]        w_byteMask;
  logic               w_inc;
  logic [63:0]        w_mtimeInc;
  logic [63:0]        w_mtimeNext;
  logic [63:0]        w_cmpNext;
  logic [31:0]        w_ctrlRd;
  logic [31:0]        w_ctrlNew;
  logic [31:0]        w_pendRd;
  logic [31:0]        w_enRd;
  logic [31:0]        w_enNew;
  logic [PRESC_W-1:0] w_pcntNext;
  logic [NUM_EXT-1:0] w_extRise;
  logic [NUM_EXT-1:0] w_pendW1c;
  logic [31:0]        w_rdData;
  logic               w_tpend;
  logic               w_unusedBits;

  // Replace only the bytes whose enable is set.
  function automatic logic [31:0] mergeBytes(input logic [31:0] oldVal,
                                             input logic [31:0] newVal,
                                             input logic [31:0] byteMask);
    return (oldVal & ~byteMask) | (newVal & byteMask);
  endfunction

  assign w_wrEn     = cs & wr;
  assign w_rdEn     = cs & ~wr;
  assign w_wrSel    = w_wrEn ? (8'd1 << addr[4:2]) : 8'd0;
  assign w_byteMask = {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};

  // mtime advances on the last prescaler count; a bus write overrides only
  // the bytes it enables, so untouched bytes still see the increment.
  assign w_inc      = r_ten & (r_pcnt == r_presc);
  assign w_mtimeInc = r_mtime + {63'd0, w_inc};
  assign w_mtimeNext[31:0]  = w_wrSel[0] ? mergeBytes(w_mtimeInc[31:0], data_wr, w_byteMask)
                                         : w_mtimeInc[31:0];
  assign w_mtimeNext[63:32] = w_wrSel[1] ? mergeBytes(w_mtimeInc[63:32], data_wr, w_byteMask)
                                         : w_mtimeInc[63:32];
  assign w_cmpNext[31:0]    = w_wrSel[2] ? mergeBytes(r_mtimecmp[31:0], data_wr, w_byteMask)
                                         : r_mtimecmp[31:0];
  assign w_cmpNext[63:32]   = w_wrSel[3] ? mergeBytes(r_mtimecmp[63:32], data_wr, w_byteMask)
                                         : r_mtimecmp[63:32];

  assign w_ctrlNew = mergeBytes(w_ctrlRd, data_wr, w_byteMask);
  assign w_enNew   = mergeBytes(w_enRd, data_wr, w_byteMask);
  assign w_pendW1c = w_wrSel[5] ? (data_wr[NUM_EXT-1:0] & w_byteMask[NUM_EXT-1:0]) : '0;
  assign w_extRise = r_extSample & ~r_extPrev;
  assign w_tpend   = (r_mtime >= r_mtimecmp);

  // Address bits outside the decoded window and the unimplemented register
  // bits are deliberately ignored.
  assign w_unusedBits = ^{addr[31:5], addr[1:0], w_ctrlNew, w_enNew};

  // Zero-extended views of the narrow registers as the bus sees them.
  always_comb begin
    w_ctrlRd                = '0;
    w_ctrlRd[0]             = r_ten;
    w_ctrlRd[1]             = r_tie;
    w_ctrlRd[8 +: PRESC_W]  = r_presc;
    w_pendRd                = '0;
    w_pendRd[NUM_EXT-1:0]   = r_extPend;
    w_enRd                  = '0;
    w_enRd[NUM_EXT-1:0]     = r_extEn;
  end

  // Prescaler counts 0..PRESC while enabled; any CTRL write restarts it.
  always_comb begin
    w_pcntNext = r_pcnt;
    if (w_wrSel[OFF_CTRL]) begin
      w_pcntNext = '0;
    end else if (r_ten) begin
      w_pcntNext = (r_pcnt == r_presc) ? '0 : r_pcnt + PRESC_W'(1);
    end
  end

  // Register read multiplexer; the reserved offset reads as zero.
  always_comb begin
    w_rdData = '0;
    case (addr[4:2])
      OFF_MTIME_LO: w_rdData = r_mtime[31:0];
      OFF_MTIME_HI: w_rdData = r_mtime[63:32];
      OFF_CMP_LO:   w_rdData = r_mtimecmp[31:0];
      OFF_CMP_HI:   w_rdData = r_mtimecmp[63:32];
      OFF_CTRL:     w_rdData = w_ctrlRd;
      OFF_PEND:     w_rdData = w_pendRd;
      OFF_EN:       w_rdData = w_enRd;
      default:      w_rdData = '0;
    endcase
  end

  // Timer, compare and control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mtime    <= '0;
      r_mtimecmp <= '1;
      r_ten      <= 1'b0;
      r_tie      <= 1'b0;
      r_presc    <= '0;
      r_pcnt     <= '0;
    end else begin
      r_mtime    <= w_mtimeNext;
      r_mtimecmp <= w_cmpNext;
      r_pcnt     <= w_pcntNext;
      if (w_wrSel[OFF_CTRL]) begin
        r_ten   <= w_ctrlNew[0];
        r_tie   <= w_ctrlNew[1];
        r_presc <= w_ctrlNew[8 +: PRESC_W];
      end
    end
  end

`ifdef IRQ_TIMER_EXT_SYNC_EN
  logic [NUM_EXT-1:0] r_extMeta;

  // Two-flop synchronizer for truly asynchronous external lines.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_extMeta   <= '0;
      r_extSample <= '0;
    end else begin
      r_extMeta   <= ext_irq;
      r_extSample <= r_extMeta;
    end
  end
`else
  // Single sampling flop; sources must already be synchronous to clk.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_extSample <= '0;
    end else begin
      r_extSample <= ext_irq;
    end
  end
`endif

  // Rising-edge detection, pending (set beats write-1-to-clear) and enables.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_extPrev <= '0;
      r_extPend <= '0;
      r_extEn   <= '0;
    end else begin
      r_extPrev <= r_extSample;
      r_extPend <= (r_extPend & ~w_pendW1c) | w_extRise;
      if (w_wrSel[OFF_EN]) begin
        r_extEn <= w_enNew[NUM_EXT-1:0];
      end
    end
  end

  // Bus response: one valid pulse per request, read data held until next read.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid   <= 1'b0;
      data_rd <= '0;
    end else begin
      valid <= cs;
      if (w_rdEn) begin
        data_rd <= w_rdData;
      end
    end
  end

  // Registered interrupt request combining the timer and enabled external lines.
  always_ff @(posedge clk) begin
    if (rst) begin
      interrupt <= 1'b0;
    end else begin
      interrupt <= (w_tpend & r_tie) | (|(r_extPend & r_extEn));
    end
  end

endmodule
